// File: rtl/debounce_scan_pkg.sv
// Shared types and width helpers for the debounce scan scheduler.
package debounce_scan_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'b00,
    S_SAMPLE = 2'b01,
    S_COMMIT = 2'b10
  } scan_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_event_arbiter.sv
// Round-robin picker draining a pending vector through a valid/ready port.
// The granted channel is registered, so it stays stable while the consumer stalls.
module rr_event_arbiter
  import debounce_scan_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pending,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] ch,
  output logic [N-1:0] clear,
  output logic [W-1:0] last_granted
);

  logic [W-1:0] pick;
  logic [W-1:0] cand;
  logic         found;

  // First set pending bit searching upward from the channel after the last grant.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = W'((int'(last_granted) + k) % N);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // One-cycle clear strobe for the channel accepted this cycle.
  always_comb begin
    clear = '0;
    if (valid && ready) clear[ch] = 1'b1;
  end

  // Present a grant, hold it until accepted, then idle one cycle before re-arbitrating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid        <= 1'b0;
      ch           <= '0;
      last_granted <= W'(N - 1);
    end else if (valid) begin
      if (ready) begin
        valid        <= 1'b0;
        last_granted <= ch;
      end
    end else if (found) begin
      valid <= 1'b1;
      ch    <= pick;
    end
  end

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Multi-channel button debouncer sharing one scan timer; committed level
// changes are queued as pending events and drained by a round-robin arbiter.
//
// state    | meaning
// S_WAIT   | idle until the next scan tick
// S_SAMPLE | compare synced input of channel idx with its level, update counter
// S_COMMIT | flip level if the counter reached the threshold, advance idx
module debounce_scan_scheduler
  import debounce_scan_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CHANNELS-1:0]         i_buttons,
  output logic [CHANNELS-1:0]         o_state,
  output logic                        o_event_valid,
  input  logic                        i_event_ready,
  output logic [$clog2(CHANNELS)-1:0] o_event_ch,
  output logic                        o_event_level,
  output logic                        o_overflow
);

  localparam int CH_W  = idx_width(CHANNELS);
  localparam int PS_W  = idx_width(TICK_DIV);
  localparam int CNT_W = idx_width(STABLE_TICKS + 1);

  logic [CHANNELS-1:0] sync1, sync2;
  logic [PS_W-1:0]     presc;
  logic                tick;
  scan_state_t         state, state_next;
  logic                sample_en, commit_en;
  logic [CH_W-1:0]     idx;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] commit_set;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] arb_clear;
  logic [CH_W-1:0]     last_granted_unused;

  // Two-flop synchronizer on the raw button levels.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_buttons;
      sync2 <= sync1;
    end
  end

  assign tick = (presc == PS_W'(TICK_DIV - 1));

  // Free-running scan-slot prescaler.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Scan FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_WAIT;
    else          state <= state_next;
  end

  // Scan FSM next state and phase strobes.
  always_comb begin
    state_next = state;
    sample_en  = 1'b0;
    commit_en  = 1'b0;
    case (state)
      S_WAIT:   if (tick) state_next = S_SAMPLE;
      S_SAMPLE: begin
        sample_en  = 1'b1;
        state_next = S_COMMIT;
      end
      S_COMMIT: begin
        commit_en  = 1'b1;
        state_next = S_WAIT;
      end
      default:  state_next = S_WAIT;
    endcase
  end

  // Channel whose debounced level flips this cycle.
  always_comb begin
    commit_set = '0;
    if (commit_en && (cnt[idx] == CNT_W'(STABLE_TICKS))) commit_set[idx] = 1'b1;
  end

  // Stability counters, debounced levels and scan index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idx     <= '0;
      o_state <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      if (sample_en) begin
        if (sync2[idx] == o_state[idx]) cnt[idx] <= '0;
        else                            cnt[idx] <= cnt[idx] + 1'b1;
      end
      if (commit_en) begin
        if (commit_set[idx]) cnt[idx] <= '0;
        o_state <= o_state ^ commit_set;
        idx     <= (idx == CH_W'(CHANNELS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pending events: a new commit wins over a same-cycle clear; re-setting an unconsumed bit is a lost event.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending    <= '0;
      o_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~arb_clear) | commit_set;
      if (|(commit_set & pending & ~arb_clear)) o_overflow <= 1'b1;
    end
  end

  rr_event_arbiter #(
    .N (CHANNELS),
    .W (CH_W)
  ) u_arb (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .pending      (pending),
    .ready        (i_event_ready),
    .valid        (o_event_valid),
    .ch           (o_event_ch),
    .clear        (arb_clear),
    .last_granted (last_granted_unused)
  );

  assign o_event_level = o_state[o_event_ch];

endmodule
